// File: rtl/multicycle_alu_if.sv
// Operand/result bus between the multi-cycle control FSM and multicycle_alu.
// Each side transfers on a clock edge where valid & ready are both high. The sender holds valid and payload steady until then; ready may move freely.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [5:0]       operation;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] aluResult;
    logic             zero;
    logic             divByZero;

    modport master (
        output inValid, data1, data2, operation, outReady,
        input  inReady, outValid, aluResult, zero, divByZero
    );

    modport slave (
        input  inValid, data1, data2, operation, outReady,
        output inReady, outValid, aluResult, zero, divByZero
    );
endinterface

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/arith/compare ops, iterative 1-bit/cycle multiply and restoring divide.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    multicycle_alu_if.slave bus,
    output logic [1:0]      o_dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_AND = 6'h03;
    localparam logic [5:0] OP_OR  = 6'h04;
    localparam logic [5:0] OP_XOR = 6'h05;
    localparam logic [5:0] OP_NOT = 6'h06;
    localparam logic [5:0] OP_SHL = 6'h07;
    localparam logic [5:0] OP_SHR = 6'h08;
    localparam logic [5:0] OP_MUL = 6'h09;
    localparam logic [5:0] OP_DIV = 6'h0A;
    localparam logic [5:0] OP_MOD = 6'h0B;
    localparam logic [5:0] OP_PSB = 6'h20;
    localparam logic [5:0] OP_EQ  = 6'h21;
    localparam logic [5:0] OP_NE  = 6'h22;

    localparam logic [6:0] LP_LAST = 7'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [5:0]       r_op;
    logic [6:0]       r_cnt;
    // r_a: multiplicand (MUL) or dividend shifting into quotient (DIV); r_b: multiplier or divisor.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_dbz;

    logic             w_in_ready;
    logic             w_is_divmod;
    logic [WIDTH-1:0] w_comb_result;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_rem_diff;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_final;

    assign w_in_ready  = reset_n && (r_state == S_IDLE);
    assign w_is_divmod = (bus.operation == OP_DIV) || (bus.operation == OP_MOD);

    // Div/mod entries here only reach the result register when B==0.
    always_comb begin
        w_comb_result = bus.data1;
        case (bus.operation)
            OP_ADD:  w_comb_result = bus.data1 + bus.data2;
            OP_SUB:  w_comb_result = bus.data1 - bus.data2;
            OP_AND:  w_comb_result = bus.data1 & bus.data2;
            OP_OR:   w_comb_result = bus.data1 | bus.data2;
            OP_XOR:  w_comb_result = bus.data1 ^ bus.data2;
            OP_NOT:  w_comb_result = ~bus.data1;
            OP_SHL:  w_comb_result = bus.data1 << bus.data2;
            OP_SHR:  w_comb_result = bus.data1 >> bus.data2;
            OP_DIV:  w_comb_result = '1;
            OP_MOD:  w_comb_result = bus.data1;
            OP_PSB:  w_comb_result = bus.data2;
            OP_EQ:   w_comb_result = {{(WIDTH-1){1'b0}}, bus.data1 == bus.data2};
            OP_NE:   w_comb_result = {{(WIDTH-1){1'b0}}, bus.data1 != bus.data2};
            default: w_comb_result = bus.data1;
        endcase
    end

    always_comb begin
        w_acc_next  = r_b[0] ? (r_acc + r_a) : r_acc;
        w_rem_shift = {r_rem[WIDTH-1:0], r_a[WIDTH-1]};
        w_rem_diff  = w_rem_shift - {1'b0, r_b};
        w_rem_next  = w_rem_diff[WIDTH] ? w_rem_shift : w_rem_diff;
        w_quot_next = {r_a[WIDTH-2:0], ~w_rem_diff[WIDTH]};
        if (r_state == S_MUL)
            w_final = w_acc_next;
        else if (r_op == OP_DIV)
            w_final = w_quot_next;
        else
            w_final = w_rem_next[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.inValid) begin
                        r_op  <= bus.operation;
                        r_a   <= bus.data1;
                        r_b   <= bus.data2;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_rem <= '0;
                        if (bus.operation == OP_MUL) begin
                            r_state <= S_MUL;
                        end else if (w_is_divmod && (bus.data2 != '0)) begin
                            r_state <= S_DIV;
                        end else begin
                            r_result <= w_comb_result;
                            r_zero   <= (w_comb_result == '0);
                            r_dbz    <= w_is_divmod;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_cnt <= r_cnt + 7'd1;
                    if (r_state == S_MUL) begin
                        r_acc <= w_acc_next;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else begin
                        r_rem <= w_rem_next;
                        r_a   <= w_quot_next;
                    end
                    if (r_cnt == LP_LAST) begin
                        r_result <= w_final;
                        r_zero   <= (w_final == '0);
                        r_dbz    <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.outReady)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.inReady   = w_in_ready;
    assign bus.outValid  = (r_state == S_DONE);
    assign bus.aluResult = r_result;
    assign bus.zero      = r_zero;
    assign bus.divByZero = r_dbz;
    assign o_dbg_state   = r_state;
endmodule
